// File: rtl/cpu_stream_arbiter.sv
// rtl/cpu_stream_arbiter.sv - per-source FIFOs merged round-robin into one registered valid/ready stream
module cpu_stream_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           src_vld,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    input  logic [NUM_SRC-1:0]           ovf_clr,
    output logic [NUM_SRC-1:0]           src_ovf,
    output logic                         out_vld,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_SRC)-1:0]   out_src,
    output logic [NUM_SRC-1:0]           fifo_empty
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    // FIFO storage and pointers; the extra pointer bit tells full from empty
    logic [DATA_W-1:0] mem_q [NUM_SRC][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q [NUM_SRC];
    logic [PW-1:0]     wr_ptr_d [NUM_SRC];
    logic [PW-1:0]     rd_ptr_q [NUM_SRC];
    logic [PW-1:0]     rd_ptr_d [NUM_SRC];

    logic [NUM_SRC-1:0] ovf_q, ovf_d;
    logic [NUM_SRC-1:0] empty, full, pop_vec, push_ok, drop;

    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SW-1:0]     out_src_q, out_src_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;

    logic              load, pop, grant_vld;
    logic [SW-1:0]     grant_idx;
    logic [SW:0]       scan_idx;
    logic [DATA_W-1:0] head_data;

    // Per-source occupancy from pointer comparison
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                       (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
        end
    end

    // Round-robin pick: first non-empty source scanning upward from rr_ptr, wrapping
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (scan_idx >= (SW+1)'(NUM_SRC)) begin
                scan_idx = scan_idx - (SW+1)'(NUM_SRC);
            end
            if (!grant_vld && !empty[scan_idx[SW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[SW-1:0];
            end
        end
        head_data = mem_q[grant_idx][rd_ptr_q[grant_idx][AW-1:0]];
    end

    // Push/pop decisions; a pop frees the slot a same-cycle push into a full FIFO needs
    always_comb begin
        load    = !out_vld_q || out_ready;
        pop     = load && grant_vld;
        pop_vec = '0;
        push_ok = '0;
        drop    = '0;
        ovf_d   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop_vec[i]  = pop && (grant_idx == SW'(i));
            push_ok[i]  = src_vld[i] && (!full[i] || pop_vec[i]);
            drop[i]     = src_vld[i] && full[i] && !pop_vec[i];
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push_ok[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop_vec[i]);
            ovf_d[i]    = drop[i] || (ovf_q[i] && !ovf_clr[i]);
        end
    end

    // Output register next state; data and source hold unless a new word is loaded
    always_comb begin
        out_vld_d  = load ? grant_vld : out_vld_q;
        out_data_d = pop ? head_data : out_data_q;
        out_src_d  = pop ? grant_idx : out_src_q;
        rr_ptr_d   = rr_ptr_q;
        if (pop) begin
            rr_ptr_d = (grant_idx == SW'(NUM_SRC - 1)) ? '0 : grant_idx + SW'(1);
        end
    end

    // Control state with asynchronous reset; everything in flight is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            ovf_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            ovf_q      <= ovf_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // FIFO storage writes; contents are meaningless once pointers reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign src_ovf    = ovf_q;
    assign out_vld    = out_vld_q;
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign fifo_empty = empty;

endmodule

// File: tb/tb_cpu_stream_arbiter.sv
// tb/tb_cpu_stream_arbiter.sv - vector table, corner sequences and random run against a queue model
module tb_cpu_stream_arbiter;

    localparam int NS = 4;
    localparam int DW = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NS-1:0]   src_vld = '0;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS-1:0]   ovf_clr = '0;
    logic [NS-1:0]   src_ovf;
    logic            out_vld;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic [NS-1:0]   fifo_empty;

    int checks = 0;
    int errors = 0;

    cpu_stream_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .src_vld(src_vld), .src_data(src_data),
        .ovf_clr(ovf_clr), .src_ovf(src_ovf), .out_vld(out_vld), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per source plus the output word and priority index
    logic [DW-1:0] mq [NS][$];
    logic          m_vld;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_ptr;
    logic [NS-1:0] m_ovf;

    function automatic logic [DW-1:0] mk(int n, int i);
        return {16'hA5A5, 16'(n), 16'h0, 16'(i)};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_vld = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_ovf = '0;
    endtask

    // What the next clock edge does, given the inputs currently driven
    task automatic model_step();
        logic [NS-1:0] set;
        set = '0;
        if (!m_vld || out_ready) begin
            int g;
            g = -1;
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (m_ptr + k) % NS;
                if (g < 0 && mq[s].size() > 0) g = s;
            end
            if (g >= 0) begin
                m_data = mq[g].pop_front();
                m_src  = g;
                m_vld  = 1'b1;
                m_ptr  = (g + 1) % NS;
            end else begin
                m_vld = 1'b0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (src_vld[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(src_data[i*DW +: DW]);
                else set[i] = 1'b1;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (set[i]) m_ovf[i] = 1'b1;
            else if (ovf_clr[i]) m_ovf[i] = 1'b0;
        end
    endtask

    task automatic compare(string tag);
        logic [NS-1:0] e;
        for (int i = 0; i < NS; i++) e[i] = (mq[i].size() == 0);
        chk({tag, ".out_vld"}, 64'(out_vld), 64'(m_vld));
        chk({tag, ".out_data"}, out_data, m_data);
        chk({tag, ".out_src"}, 64'(out_src), 64'(m_src));
        chk({tag, ".src_ovf"}, 64'(src_ovf), 64'(m_ovf));
        chk({tag, ".fifo_empty"}, 64'(fifo_empty), 64'(e));
    endtask

    task automatic cycle(string tag);
        model_step();
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic do_reset();
        src_vld = '0; ovf_clr = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [NS-1:0] vld;
        logic          t1;
        logic          ev;
        logic [1:0]    es;
        logic [DW-1:0] ed;
    } vec_t;

    localparam logic [DW-1:0] T1_DATA = 64'hdeadbeefdeadbef1;

    vec_t tbl[13];
    logic [DW-1:0] got[$];
    logic [DW-1:0] hold_d;
    logic [1:0]    hold_s;

    initial begin
        tbl[0]  = '{4'hF, 1'b0, 1'b0, 2'd0, '0};
        tbl[1]  = '{4'h0, 1'b0, 1'b1, 2'd0, mk(0, 0)};
        tbl[2]  = '{4'h0, 1'b0, 1'b1, 2'd1, mk(0, 1)};
        tbl[3]  = '{4'h0, 1'b0, 1'b1, 2'd2, mk(0, 2)};
        tbl[4]  = '{4'h0, 1'b0, 1'b1, 2'd3, mk(0, 3)};
        tbl[5]  = '{4'hF, 1'b0, 1'b0, 2'd3, mk(0, 3)};
        tbl[6]  = '{4'h0, 1'b0, 1'b1, 2'd0, mk(5, 0)};
        tbl[7]  = '{4'h0, 1'b0, 1'b1, 2'd1, mk(5, 1)};
        tbl[8]  = '{4'h0, 1'b0, 1'b1, 2'd2, mk(5, 2)};
        tbl[9]  = '{4'h0, 1'b0, 1'b1, 2'd3, mk(5, 3)};
        tbl[10] = '{4'h4, 1'b1, 1'b0, 2'd3, mk(5, 3)};
        tbl[11] = '{4'h0, 1'b0, 1'b1, 2'd2, T1_DATA};
        tbl[12] = '{4'h0, 1'b0, 1'b0, 2'd2, T1_DATA};

        do_reset();
        chk("reset.out_vld", 64'(out_vld), 64'd0);
        chk("reset.out_data", out_data, 64'd0);
        chk("reset.out_src", 64'(out_src), 64'd0);
        chk("reset.src_ovf", 64'(src_ovf), 64'd0);
        chk("reset.fifo_empty", 64'(fifo_empty), 64'hF);

        // Fairness bursts followed by the single-word case
        out_ready = 1'b1;
        for (int n = 0; n < 13; n++) begin
            src_vld = tbl[n].vld;
            for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = mk(n, i);
            if (tbl[n].t1) src_data[2*DW +: DW] = T1_DATA;
            cycle("tbl");
            chk($sformatf("vec%0d.out_vld", n), 64'(out_vld), 64'(tbl[n].ev));
            chk($sformatf("vec%0d.out_src", n), 64'(out_src), 64'(tbl[n].es));
            chk($sformatf("vec%0d.out_data", n), out_data, tbl[n].ed);
        end
        src_vld = '0;

        // Backpressure: the presented word must not move while out_ready is low
        out_ready = 1'b0;
        src_vld = 4'hF;
        for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = mk(20, i);
        cycle("bp.push");
        src_vld = '0;
        for (int c = 0; c < 10; c++) begin
            cycle("bp.hold");
            if (c == 0) begin
                hold_d = out_data; hold_s = out_src;
                chk("bp.first_vld", 64'(out_vld), 64'd1);
                chk("bp.first_src", 64'(out_src), 64'd3);
            end else begin
                chk("bp.stable_vld", 64'(out_vld), 64'd1);
                chk("bp.stable_data", out_data, hold_d);
                chk("bp.stable_src", 64'(out_src), 64'(hold_s));
            end
        end
        out_ready = 1'b1;
        cycle("bp.accept");
        chk("bp.next_src", 64'(out_src), 64'd0);
        for (int c = 0; c < 5; c++) cycle("bp.drain");

        // Overflow of source 1 with the output stalled
        do_reset();
        out_ready = 1'b0;
        src_vld = 4'h2;
        for (int p = 0; p < DEPTH + 2; p++) begin
            src_data[1*DW +: DW] = mk(40 + p, 1);
            cycle("ovf.push");
            if (p == DEPTH) chk("ovf.before_drop", 64'(src_ovf[1]), 64'd0);
            if (p == DEPTH + 1) chk("ovf.after_drop", 64'(src_ovf[1]), 64'd1);
        end
        src_vld = '0;
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 8; c++) begin
            if (out_vld && out_ready) got.push_back(out_data);
            cycle("ovf.drain");
        end
        chk("ovf.count", 64'(got.size()), 64'(DEPTH + 1));
        for (int p = 0; p < got.size() && p < DEPTH + 1; p++)
            chk($sformatf("ovf.word%0d", p), got[p], mk(40 + p, 1));
        ovf_clr = 4'h2;
        cycle("ovf.clr");
        ovf_clr = '0;
        chk("ovf.cleared", 64'(src_ovf[1]), 64'd0);

        // Push into a full FIFO in the same cycle it is popped
        do_reset();
        out_ready = 1'b0;
        src_vld = 4'h1;
        got.delete();
        for (int p = 0; p < DEPTH + 1; p++) begin
            src_data[DW-1:0] = mk(60 + p, 0);
            cycle("full.fill");
        end
        out_ready = 1'b1;
        src_data[DW-1:0] = mk(60 + DEPTH + 1, 0);
        if (out_vld && out_ready) got.push_back(out_data);
        cycle("full.pushpop");
        chk("full.no_ovf", 64'(src_ovf[0]), 64'd0);
        src_vld = '0;
        for (int c = 0; c < 8; c++) begin
            if (out_vld && out_ready) got.push_back(out_data);
            cycle("full.drain");
        end
        chk("full.count", 64'(got.size()), 64'(DEPTH + 2));
        for (int p = 0; p < got.size() && p < DEPTH + 2; p++)
            chk($sformatf("full.word%0d", p), got[p], mk(60 + p, 0));

        // Asynchronous reset while streaming
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            src_vld = NS'($urandom);
            for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = {$urandom, $urandom};
            cycle("rst.stream");
        end
        src_vld = 4'hF;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.out_vld", 64'(out_vld), 64'd0);
        chk("rst.fifo_empty", 64'(fifo_empty), 64'hF);
        src_vld = '0;
        #2;
        rst_n = 1'b1;
        cycle("rst.idle");
        src_vld = 4'hF;
        for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = mk(80, i);
        cycle("rst.push");
        src_vld = '0;
        cycle("rst.grant");
        chk("rst.first_vld", 64'(out_vld), 64'd1);
        chk("rst.first_src", 64'(out_src), 64'd0);
        for (int c = 0; c < 4; c++) cycle("rst.drain");

        // Random traffic with bursts of stall to exercise overflow and clears
        for (int c = 0; c < 2000; c++) begin
            src_vld = NS'($urandom);
            for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = {$urandom, $urandom};
            out_ready = ((c / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0) ? NS'($urandom) : '0;
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
